// File: rtl/key_pkg.sv
// Shared types and default timing for the key debouncer.
// Auto-repeat is enabled by defining KEY_DEBOUNCE_REPEAT_EN.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_state_t;

   // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
   localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
   localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer plus press/release FSM.
// Auto-repeat pulses are built only when KEY_DEBOUNCE_REPEAT_EN is defined.
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int unsigned DebounceCycles = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned RepeatDelay    = DEF_REPEAT_DELAY,
   parameter int unsigned RepeatPeriod   = DEF_REPEAT_PERIOD
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       key_raw,
   output logic       key_level,
   output logic       press_pls,
   output logic       release_pls,
   output key_state_t state
);

   localparam int unsigned CntW = $clog2(max3(DebounceCycles, RepeatDelay, RepeatPeriod) + 1);
   localparam logic [CntW-1:0] DbLast = CntW'(DebounceCycles - 1);

   logic            sync_q1;
   logic            key_s;
   logic [CntW-1:0] cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q1 <= 1'b1;
         key_s   <= 1'b1;
      end else begin
         sync_q1 <= key_raw;
         key_s   <= sync_q1;
      end
   end

`ifdef KEY_DEBOUNCE_REPEAT_EN
   localparam logic [CntW-1:0] RptFirstLast = CntW'(RepeatDelay - 1);
   localparam logic [CntW-1:0] RptNextLast  = CntW'(RepeatPeriod - 1);

   logic [CntW-1:0] rpt_cnt;
   logic            rpt_first;
   logic [CntW-1:0] rpt_last;

   assign rpt_last = rpt_first ? RptFirstLast : RptNextLast;
`endif

   // Valid/ready does not apply here: press_pls/release_pls are single-cycle
   // strobes with no back-pressure, and key_level follows the FSM state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         cnt         <= '0;
         key_level   <= 1'b0;
         press_pls   <= 1'b0;
         release_pls <= 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
         rpt_cnt     <= '0;
         rpt_first   <= 1'b1;
`endif
      end else begin
         press_pls   <= 1'b0;
         release_pls <= 1'b0;
         case (state)
            IDLE: begin
               if (!key_s) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (key_s) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == DbLast) begin
                  state     <= PRESSED;
                  cnt       <= '0;
                  key_level <= 1'b1;
                  press_pls <= 1'b1;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                  rpt_cnt   <= '0;
                  rpt_first <= 1'b1;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (key_s) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end
`ifdef KEY_DEBOUNCE_REPEAT_EN
               else if (rpt_cnt == rpt_last) begin
                  press_pls <= 1'b1;
                  rpt_cnt   <= '0;
                  rpt_first <= 1'b0;
               end else begin
                  rpt_cnt <= rpt_cnt + 1'b1;
               end
`endif
            end
            RELEASE_WAIT: begin
               // the repeat counter is frozen here and resumes on a bounce back
               if (!key_s) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt == DbLast) begin
                  state       <= IDLE;
                  cnt         <= '0;
                  key_level   <= 1'b0;
                  release_pls <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: NKeys independent key_debounce_ch channels.
// Define KEY_DEBOUNCE_REPEAT_EN to enable auto-repeat press pulses.
module key_debounce
   import key_pkg::*;
#(
   parameter int unsigned NKeys          = 4,
   parameter int unsigned DebounceCycles = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned RepeatDelay    = DEF_REPEAT_DELAY,
   parameter int unsigned RepeatPeriod   = DEF_REPEAT_PERIOD
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [NKeys-1:0]   key_i,
   output logic [NKeys-1:0]   key_level_o,
   output logic [NKeys-1:0]   press_o,
   output logic [NKeys-1:0]   release_o,
   output logic [2*NKeys-1:0] dbg_state
);

   for (genvar g = 0; g < NKeys; g++) begin : g_ch
      key_state_t ch_state;

      key_debounce_ch #(
         .DebounceCycles (DebounceCycles),
         .RepeatDelay    (RepeatDelay),
         .RepeatPeriod   (RepeatPeriod)
      ) u_ch (
         .clk         (clk),
         .rstn        (rstn),
         .key_raw     (key_i[g]),
         .key_level   (key_level_o[g]),
         .press_pls   (press_o[g]),
         .release_pls (release_o[g]),
         .state       (ch_state)
      );

      assign dbg_state[2*g +: 2] = ch_state;
   end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random key activity,
// checked every cycle against a run-length model of the debouncer.
module tb_key_debounce;
   import key_pkg::*;

   localparam int NK = 4;
   localparam int DC = 4;
   localparam int RD = 8;
   localparam int RP = 4;

   logic            clk;
   logic            rstn;
   logic [NK-1:0]   key_i;
   logic [NK-1:0]   key_level_o;
   logic [NK-1:0]   press_o;
   logic [NK-1:0]   release_o;
   logic [2*NK-1:0] dbg_state;

   int total = 0;
   int bad   = 0;

   // reference model: raw pin delayed two samples, then a run of
   // DC+1 samples disagreeing with the accepted level flips it
   bit            s1_m[NK];
   bit            s2_m[NK];
   bit            lvl_m[NK];
   int            run_m[NK];
   int            held_m[NK];
   int            next_m[NK];
   logic [NK-1:0] exp_lvl, exp_press, exp_rel;

   key_debounce #(
      .NKeys          (NK),
      .DebounceCycles (DC),
      .RepeatDelay    (RD),
      .RepeatPeriod   (RP)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .key_i       (key_i),
      .key_level_o (key_level_o),
      .press_o     (press_o),
      .release_o   (release_o),
      .dbg_state   (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int k = 0; k < NK; k++) begin
         s1_m[k]   = 1'b1;
         s2_m[k]   = 1'b1;
         lvl_m[k]  = 1'b0;
         run_m[k]  = 0;
         held_m[k] = 0;
         next_m[k] = RD;
      end
      exp_lvl   = '0;
      exp_press = '0;
      exp_rel   = '0;
   endtask

   task automatic check_vec(input string tag, input logic [NK-1:0] got, input logic [NK-1:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic got, input logic exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
      end
   endtask

   task automatic check_model();
      check_vec("level", key_level_o, exp_lvl);
      check_vec("press", press_o, exp_press);
      check_vec("release", release_o, exp_rel);
   endtask

   // one clock: advance the model on the edge, compare #1 later
   task automatic tick();
      logic [NK-1:0] raw;
      bit            ks_pressed;
      raw = key_i;
      @(posedge clk);
      if (!rstn) begin
         model_reset();
      end else begin
         for (int k = 0; k < NK; k++) begin
            ks_pressed   = (s2_m[k] == 1'b0);
            s2_m[k]      = s1_m[k];
            s1_m[k]      = raw[k];
            exp_press[k] = 1'b0;
            exp_rel[k]   = 1'b0;
            if (ks_pressed != lvl_m[k]) begin
               run_m[k]++;
               if (run_m[k] == DC + 1) begin
                  lvl_m[k] = ks_pressed;
                  run_m[k] = 0;
                  if (ks_pressed) begin
                     exp_press[k] = 1'b1;
                     held_m[k]    = 0;
                     next_m[k]    = RD;
                  end else begin
                     exp_rel[k] = 1'b1;
                  end
               end
            end else begin
`ifdef KEY_DEBOUNCE_REPEAT_EN
               if (lvl_m[k] && run_m[k] == 0) begin
                  held_m[k]++;
                  if (held_m[k] == next_m[k]) begin
                     exp_press[k] = 1'b1;
                     held_m[k]    = 0;
                     next_m[k]    = RP;
                  end
               end
`endif
               run_m[k] = 0;
            end
            exp_lvl[k] = lvl_m[k];
         end
      end
      #1;
      check_model();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic async_reset_check(input string tag);
      rstn = 1'b0;
      model_reset();
      #1;
      check_vec({tag, "_level"}, key_level_o, '0);
      check_vec({tag, "_press"}, press_o, '0);
      check_vec({tag, "_release"}, release_o, '0);
   endtask

   initial begin
      bit rpt_on;
      bit exp_p2;
`ifdef KEY_DEBOUNCE_REPEAT_EN
      rpt_on = 1'b1;
`else
      rpt_on = 1'b0;
`endif
      rstn  = 1'b0;
      key_i = '1;
      model_reset();
      ticks(3);
      check_vec("reset_state", dbg_state[1:0], IDLE);
      check_vec("reset_state_hi", dbg_state[7:6], IDLE);
      #2 rstn = 1'b1;
      ticks(2);

      // clean press on key 0
      key_i[0] = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         check_bit($sformatf("clean_press_e%0d", e), press_o[0], (e == 7));
         check_bit($sformatf("clean_level_e%0d", e), key_level_o[0], (e >= 7));
      end

      // glitch on key 1 must not be accepted
      key_i[1] = 1'b0;
      ticks(3);
      key_i[1] = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick();
         check_bit("glitch_press", press_o[1], 1'b0);
         check_bit("glitch_level", key_level_o[1], 1'b0);
      end

      // release bounce on key 0
      key_i[0] = 1'b1;
      ticks(2);
      key_i[0] = 1'b0;
      for (int e = 0; e < 10; e++) begin
         tick();
         check_bit("bounce_release", release_o[0], 1'b0);
         check_bit("bounce_level", key_level_o[0], 1'b1);
      end

      // real release
      key_i[0] = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         check_bit($sformatf("release_e%0d", e), release_o[0], (e == 7));
      end
      ticks(4);

      // simultaneous press, then watch key 2 auto-repeat
      key_i = '0;
      for (int e = 1; e <= 26; e++) begin
         tick();
         if (e == 7) check_vec("simul_press", press_o, 4'b1111);
         exp_p2 = (e == 7) || (rpt_on && e >= 15 && ((e - 15) % 4 == 0));
         check_bit($sformatf("repeat_e%0d", e), press_o[2], exp_p2);
      end
      key_i = '1;
      ticks(12);

      // reset while in PRESS_WAIT, key kept held
      key_i[0] = 1'b0;
      ticks(4);
      async_reset_check("rst_presswait");
      ticks(2);
      rstn = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         check_bit($sformatf("rearm1_e%0d", e), press_o[0], (e == 7));
      end
      ticks(3);

      // reset while PRESSED: no release, key re-accepted as a new press
      async_reset_check("rst_pressed");
      ticks(2);
      rstn = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         check_bit($sformatf("rearm2_e%0d", e), press_o[0], (e == 7));
         check_bit("rearm2_release", release_o[0], 1'b0);
      end
      key_i = '1;
      ticks(12);

      // random key activity with occasional resets
      for (int c = 0; c < 1500; c++) begin
         for (int k = 0; k < NK; k++) begin
            if ($urandom_range(0, 5) == 0) key_i[k] = ~key_i[k];
         end
         if ($urandom_range(0, 399) == 0) begin
            async_reset_check("rand_reset");
            tick();
            rstn = 1'b1;
         end
         tick();
      end
      key_i = '1;
      ticks(12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
